// File: rtl/m2vside2_pkg.sv
// rtl/m2vside2_pkg.sv - shared constants and entry-width helpers for the stage-2 side FIFO
package m2vside2_pkg;

    // Index of the final luma/chroma block in a 4:2:0 macroblock
    localparam logic [2:0] M2V_LAST_BLOCK = 3'd5;
    localparam int         M2V_BLOCK_W    = 3;

    // Entry layout, LSB first: coded, block, mb_intra, mb_y, mb_x, mv_v, mv_h
    localparam int M2V_OFF_CODED = 0;
    localparam int M2V_OFF_BLOCK = 1;
    localparam int M2V_OFF_INTRA = 1 + M2V_BLOCK_W;
    localparam int M2V_OFF_MB_Y  = 2 + M2V_BLOCK_W;

    function automatic int m2v_off_mb_x(input int mby_w);
        return M2V_OFF_MB_Y + mby_w;
    endfunction

    function automatic int m2v_off_mv_v(input int mbx_w, input int mby_w);
        return m2v_off_mb_x(mby_w) + mbx_w;
    endfunction

    function automatic int m2v_off_mv_h(input int mvv_w, input int mbx_w, input int mby_w);
        return m2v_off_mv_v(mbx_w, mby_w) + mvv_w;
    endfunction

    function automatic int m2v_entry_width(input int mvh_w, input int mvv_w,
                                           input int mbx_w, input int mby_w);
        return m2v_off_mv_h(mvv_w, mbx_w, mby_w) + mvh_w;
    endfunction

endpackage

// File: rtl/m2vside2_fifo.sv
// rtl/m2vside2_fifo.sv - generic synchronous show-ahead FIFO with level/full/empty
module m2vside2_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      din_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    logic [WIDTH-1:0]      hold_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Head is shown directly; once drained, the last popped entry is held
    assign dout_o = empty_o ? hold_q : mem_q[rd_ptr_q];

    // Occupancy next-state
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers, level and last-popped holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                hold_q   <= mem_q[rd_ptr_q];
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/m2vside2.sv
// rtl/m2vside2.sv - stage-2 side-information FIFO; optional error flags via M2VSIDE2_ERRFLAG_EN
module m2vside2
    import m2vside2_pkg::*;
#(
    parameter int MVH_WIDTH  = 16,
    parameter int MVV_WIDTH  = 15,
    parameter int MBX_WIDTH  = 6,
    parameter int MBY_WIDTH  = 5,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MVH_WIDTH-1:0]  s1_mv_h,
    input  logic [MVV_WIDTH-1:0]  s1_mv_v,
    input  logic [MBX_WIDTH-1:0]  s1_mb_x,
    input  logic [MBY_WIDTH-1:0]  s1_mb_y,
    input  logic                  s1_mb_intra,
    input  logic [2:0]            s1_block,
    input  logic                  s1_coded,
    input  logic                  s1_enable,
    input  logic                  s1_push,
    input  logic                  s2_ack,
    output logic                  s2_valid,
    output logic [MVH_WIDTH-1:0]  s2_mv_h,
    output logic [MVV_WIDTH-1:0]  s2_mv_v,
    output logic [MBX_WIDTH-1:0]  s2_mb_x,
    output logic [MBY_WIDTH-1:0]  s2_mb_y,
    output logic                  s2_mb_intra,
    output logic [2:0]            s2_block,
    output logic                  s2_coded,
    output logic                  s2_mb_last,
    output logic                  s2_full,
    output logic [DEPTH_LOG2:0]   s2_level,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int ENTRY_W = m2v_entry_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               push_req;
    logic               fifo_empty;

    // Stale bundles (enable low) never enter the FIFO
    assign push_req = s1_push & s1_enable;

    assign wr_entry = {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, s1_block, s1_coded};
    assign {s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_block, s2_coded} = rd_entry;

    assign s2_valid   = ~fifo_empty;
    assign s2_mb_last = (s2_block == M2V_LAST_BLOCK) & s2_valid;

    m2vside2_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (s2_ack),
        .din_i   (wr_entry),
        .dout_o  (rd_entry),
        .empty_o (fifo_empty),
        .full_o  (s2_full),
        .level_o (s2_level)
    );

`ifdef M2VSIDE2_ERRFLAG_EN
    logic err_overflow_q;
    logic err_underflow_q;

    // Sticky flags: a dropped push (full, no head leaving) or an ack with nothing to take
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            if (push_req && s2_full && !(s2_ack && s2_valid)) begin
                err_overflow_q <= 1'b1;
            end
            if (s2_ack && !s2_valid) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_m2vside2.sv
// tb/tb_m2vside2.sv - self-checking bench for m2vside2 against a queue reference model
module tb_m2vside2;

    typedef struct packed {
        logic [15:0] mh;
        logic [14:0] mv;
        logic [5:0]  x;
        logic [4:0]  y;
        logic        intr;
        logic [2:0]  blk;
        logic        cd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s1_mv_h;
    logic [14:0] s1_mv_v;
    logic [5:0]  s1_mb_x;
    logic [4:0]  s1_mb_y;
    logic        s1_mb_intra;
    logic [2:0]  s1_block;
    logic        s1_coded;
    logic        s1_enable;
    logic        s1_push;
    logic        s2_ack;
    logic        s2_valid;
    logic [15:0] s2_mv_h;
    logic [14:0] s2_mv_v;
    logic [5:0]  s2_mb_x;
    logic [4:0]  s2_mb_y;
    logic        s2_mb_intra;
    logic [2:0]  s2_block;
    logic        s2_coded;
    logic        s2_mb_last;
    logic        s2_full;
    logic [2:0]  s2_level;
    logic        err_overflow;
    logic        err_underflow;

    m2vside2 dut (
        .clk           (clk),
        .reset         (reset),
        .s1_mv_h       (s1_mv_h),
        .s1_mv_v       (s1_mv_v),
        .s1_mb_x       (s1_mb_x),
        .s1_mb_y       (s1_mb_y),
        .s1_mb_intra   (s1_mb_intra),
        .s1_block      (s1_block),
        .s1_coded      (s1_coded),
        .s1_enable     (s1_enable),
        .s1_push       (s1_push),
        .s2_ack        (s2_ack),
        .s2_valid      (s2_valid),
        .s2_mv_h       (s2_mv_h),
        .s2_mv_v       (s2_mv_v),
        .s2_mb_x       (s2_mb_x),
        .s2_mb_y       (s2_mb_y),
        .s2_mb_intra   (s2_mb_intra),
        .s2_block      (s2_block),
        .s2_coded      (s2_coded),
        .s2_mb_last    (s2_mb_last),
        .s2_full       (s2_full),
        .s2_level      (s2_level),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    localparam int CAP = 4;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];
    logic m_ovf;
    logic m_udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ent_t h;
        logic exp_ovf;
        logic exp_udf;
`ifdef M2VSIDE2_ERRFLAG_EN
        exp_ovf = m_ovf;
        exp_udf = m_udf;
`else
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
`endif
        chk("valid", 64'(s2_valid), 64'(q.size() != 0));
        chk("level", 64'(s2_level), 64'(q.size()));
        chk("full", 64'(s2_full), 64'(q.size() == CAP));
        chk("ovf", 64'(err_overflow), 64'(exp_ovf));
        chk("udf", 64'(err_underflow), 64'(exp_udf));
        if (q.size() != 0) begin
            h = q[0];
            chk("head", 64'({s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_block, s2_coded}),
                64'(h));
            chk("mb_last", 64'(s2_mb_last), 64'(h.blk == 3'd5));
        end else begin
            chk("mb_last_empty", 64'(s2_mb_last), 64'(0));
        end
    endtask

    // One clock with the given stimulus, then model update and checks
    task automatic cyc(input logic p, input logic en, input logic a, input ent_t e);
        logic pop_ok;
        logic push_ok;
        s1_push = p;
        s1_enable = en;
        s2_ack = a;
        {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, s1_block, s1_coded} = e;
        @(posedge clk);
        pop_ok  = a && (q.size() > 0);
        push_ok = p && en && ((q.size() < CAP) || pop_ok);
        if (p && en && q.size() == CAP && !pop_ok) m_ovf = 1'b1;
        if (a && q.size() == 0) m_udf = 1'b1;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(e);
        #1;
        s1_push = 1'b0;
        s2_ack = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s1_push = 1'b0;
        s2_ack = 1'b0;
        @(posedge clk);
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        reset = 1'b0;
        check_model();
    endtask

    function automatic ent_t mk(input logic [15:0] mh, input logic [5:0] x, input logic [4:0] y,
                                input logic [2:0] blk, input logic cd);
        ent_t e;
        e.mh = mh;
        e.mv = 15'h1234 ^ 15'(mh);
        e.x = x;
        e.y = y;
        e.intr = blk[0];
        e.blk = blk;
        e.cd = cd;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e = ent_t'({$urandom, $urandom});
        e.blk = 3'($urandom_range(0, 5));
        return e;
    endfunction

    ent_t z;

    initial begin
        z = '0;
        reset = 1'b1;
        s1_push = 1'b0;
        s1_enable = 1'b0;
        s2_ack = 1'b0;
        {s1_mv_h, s1_mv_v, s1_mb_x, s1_mb_y, s1_mb_intra, s1_block, s1_coded} = '0;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();
        chk("rst_fields", 64'({s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_block, s2_coded}),
            64'(0));

        // Single push then ack
        cyc(1'b1, 1'b1, 1'b0, mk(16'h0123, 6'd1, 5'd1, 3'd2, 1'b1));
        chk("one_mvh", 64'(s2_mv_h), 64'h0123);
        chk("one_blk", 64'(s2_block), 64'd2);
        chk("one_lvl", 64'(s2_level), 64'd1);
        cyc(1'b0, 1'b1, 1'b1, z);
        chk("one_drain", 64'(s2_valid), 64'd0);

        // Fill, push+ack while full, then overflow and drain
        do_reset();
        for (int b = 0; b < 4; b++) cyc(1'b1, 1'b1, 1'b0, mk(16'(b), 6'd3, 5'd7, 3'(b), 1'b1));
        chk("fill_full", 64'(s2_full), 64'd1);
        cyc(1'b1, 1'b1, 1'b1, mk(16'hbeef, 6'd3, 5'd7, 3'd4, 1'b0));
        chk("pp_full_lvl", 64'(s2_level), 64'd4);
        for (int b = 4; b < 6; b++) cyc(1'b1, 1'b1, 1'b0, mk(16'(b), 6'd3, 5'd7, 3'(b), 1'b1));
        for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1, 1'b1, z);

        // Six-block MB with no acks: blocks 0..3 kept, 4 and 5 dropped
        do_reset();
        for (int b = 0; b < 6; b++) cyc(1'b1, 1'b1, 1'b0, mk(16'(b + 16), 6'd3, 5'd7, 3'(b), 1'b1));
        for (int b = 0; b < 4; b++) begin
            chk("mb_order", 64'(s2_block), 64'(b));
            cyc(1'b0, 1'b1, 1'b1, z);
        end

        // Disabled push and ack on empty
        cyc(1'b1, 1'b0, 1'b0, mk(16'h5555, 6'd2, 5'd2, 3'd1, 1'b0));
        cyc(1'b0, 1'b1, 1'b1, z);
        cyc(1'b1, 1'b1, 1'b1, mk(16'h7777, 6'd4, 5'd4, 3'd3, 1'b1));

        // Mid-operation reset with level 3, then an end-of-MB block
        do_reset();
        for (int b = 0; b < 3; b++) cyc(1'b1, 1'b1, 1'b0, mk(16'(b + 32), 6'd9, 5'd9, 3'(b), 1'b0));
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, mk(16'h0a05, 6'd5, 5'd5, 3'd5, 1'b1));
        chk("blk5_last", 64'(s2_mb_last), 64'd1);

        // Randomised traffic in phases with different push/ack pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) < 2) begin
                    do_reset();
                end else begin
                    cyc(1'($urandom_range(0, 99) < (ph == 0 ? 80 : ph == 1 ? 30 : 55)),
                        1'($urandom_range(0, 99) < 85),
                        1'($urandom_range(0, 99) < (ph == 0 ? 30 : ph == 1 ? 80 : 55)),
                        rnd_ent());
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m2vside2.md
# m2vside2

Second-stage side-information container for the MPEG2 video decoder. Sits directly downstream of `m2vside1`. Captures the per-block stage-1 side bundle (motion vector, macroblock position, intra flag, block index, coded flag) when the inverse-quantiser finishes a block. Holds the bundles in a small FIFO so the motion-compensation/reconstruction stage can consume them at its own pace, decoupled from IDCT latency.

## Interface
Parameters:
- `MVH_WIDTH`, 16, horizontal motion-vector width
- `MVV_WIDTH`, 15, vertical motion-vector width
- `MBX_WIDTH`, 6, macroblock X width
- `MBY_WIDTH`, 5, macroblock Y width
- `DEPTH_LOG2`, 2, log2 of FIFO entries (default 4 entries)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `s1_mv_h`  in  MVH_WIDTH  stage-1 horizontal MV
- `s1_mv_v`  in  MVV_WIDTH  stage-1 vertical MV
- `s1_mb_x`  in  MBX_WIDTH  stage-1 MB X
- `s1_mb_y`  in  MBY_WIDTH  stage-1 MB Y
- `s1_mb_intra`  in  1  stage-1 intra flag
- `s1_block`  in  3  stage-1 block index 0..5
- `s1_coded`  in  1  stage-1 coded flag
- `s1_enable`  in  1  stage-1 bundle valid
- `s1_push`  in  1  pulse: IQ finished current block, capture s1 bundle
- `s2_ack`  in  1  consumer takes head entry
- `s2_valid`  out  1  head entry present
- `s2_mv_h`, `s2_mv_v`, `s2_mb_x`, `s2_mb_y`, `s2_mb_intra`, `s2_block`, `s2_coded`  out  same widths as s1  head entry fields
- `s2_mb_last`  out  1  head entry is block 5 (end of macroblock)
- `s2_full`  out  1  FIFO full
- `s2_level`  out  DEPTH_LOG2+1  occupied entries
- `err_overflow`, `err_underflow`  out  1  sticky error flags (see Configuration)

## Operation
- Push condition: `s1_push & s1_enable`. A `s1_push` with `s1_enable=0` is ignored. Stale bundles after the last block of an MB are not stored.
- Entry = {mv_h, mv_v, mb_x, mb_y, mb_intra, block, coded}. Stored verbatim, with no arithmetic.
- Show-ahead: `s2_*` fields always reflect the head entry. When `s2_valid=0`, the fields hold the last popped values (don't-care for checking).
- Pop condition: `s2_ack & s2_valid`. `s2_ack` while empty is ignored and sets `err_underflow`.
- Push while full with no simultaneous pop: the entry is dropped, the FIFO is unchanged, and `err_overflow` is set.
- Push while full with a simultaneous pop is accepted. The level stays at max.
- Simultaneous push and pop when empty: the push is stored and the pop is ignored (underflow flagged).
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. The level counter is DEPTH_LOG2+1 bits, in range 0..2^DEPTH_LOG2.
- `s2_mb_last` = (`s2_block` == 3'd5) & `s2_valid`.
- `s2_full` = (level == 2^DEPTH_LOG2).
- Reset (including mid-operation) clears the pointers, the level and the error flags. Stored contents are discarded.
- Reset values: `s2_valid=0`, `s2_full=0`, `s2_level=0`, `s2_mb_last=0`, errors=0, all `s2_*` fields 0.

## Timing
- Push in cycle N (registered at edge N+1). The entry is visible at the head from N+1 if the FIFO was empty: `s2_valid=1` one cycle after the push pulse.
- Pop registered at the edge. The next entry appears, or `s2_valid` falls, in the following cycle.
- `s2_level` and `s2_full` update on the same edge as the push/pop.
- Back-to-back pushes and pops are supported every cycle. Throughput is 1 entry/cycle each way.
- Error flags rise one cycle after the offending event and stay high until reset.

## Configuration
- `M2VSIDE2_ERRFLAG_EN` defined: overflow/underflow detection logic is compiled in, and `err_overflow` and `err_underflow` behave as above.
- Not defined: the detection logic is removed and both outputs are tied to 0. Drop and ignore behaviour on full and empty is unchanged.

## Structure
- Shared package/include `m2vdefs`:
  - MB block-count constant `M2V_LAST_BLOCK = 3'd5`.
  - Side-entry field offsets and total entry width macro derived from MVH/MVV/MBX/MBY widths.
- One sub-module, `m2vside2_fifo`: generic width/depth synchronous show-ahead FIFO with level, full and empty outputs.
- The top level packs and unpacks the entry, applies the enable gating and computes `s2_mb_last`/errors.

## Test plan
- Reset then 1 push (mv_h=16'h0123, block=2, coded=1, enable=1) -> next cycle `s2_valid=1`, `s2_mv_h=16'h0123`, `s2_block=2`, `s2_level=1`. Then `s2_ack` -> `s2_valid=0`, level 0.
- 6 pushes for blocks 0..5 of MB (x=3, y=7) with no acks -> 4 stored, `s2_full=1`, 2 dropped, `err_overflow=1` (with macro). Then 4 acks -> blocks 0,1,2,3 out in order and `s2_mb_last` never asserted.
- Full FIFO with push and ack in the same cycle -> level stays 4, the new entry lands at the tail, `err_overflow` stays 0.
- `s1_push` with `s1_enable=0` -> level unchanged, `s2_valid` stays 0.
- `s2_ack` while empty -> no state change, `err_underflow=1` (with macro) or 0 (without macro).
- Reset asserted with level 3 -> next cycle `s2_valid=0`, level 0, errors 0. A subsequent push of block 5 -> `s2_mb_last=1`.
